// File: rtl/emisor_configuracion_ventana.sv
// Window-control register-write initiator: latches one request, writes three registers, pulses arranque_ventana.
// Optional macro ESCRITURA_SOLO_CAMBIOS_EN: skip writes whose value matches the last value written.
module emisor_configuracion_ventana #(
  parameter int unsigned BITS_BUS_DATOS_INSTR     = 21,
  parameter int unsigned BITS_BUS_DIRECCION_INSTR = 11,
  parameter int unsigned BITS_BUFFERS_IMAGEN      = 2,
  parameter int unsigned DIRECCION_BASE           = 0,
  parameter int unsigned CICLOS_ESPERA            = 0
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                iniciar,
  input  logic [BITS_BUS_DATOS_INSTR-1:0]     direccion_inicio_imagen,
  input  logic [BITS_BUS_DATOS_INSTR-1:0]     cantidad_lecturas,
  input  logic [BITS_BUFFERS_IMAGEN-1:0]      cantidad_buffers,
  output logic [BITS_BUS_DIRECCION_INSTR-1:0] direccion_registros,
  output logic [BITS_BUS_DATOS_INSTR-1:0]     datos_registros,
  output logic                                habilitacion_registros,
  output logic                                arranque_ventana,
  output logic                                ocupado,
  output logic                                error_config
);

  localparam int unsigned D = BITS_BUS_DATOS_INSTR;
  localparam int unsigned A = BITS_BUS_DIRECCION_INSTR;
  localparam logic [A-1:0] BASE     = A'(DIRECCION_BASE);
  localparam logic [3:0]   N_ESPERA = 4'(CICLOS_ESPERA);

  typedef enum logic [2:0] {
    REPOSO, ESCRIBIR_DIR, ESCRIBIR_LECT, ESCRIBIR_BUF, ESPERA, DISPARO
  } estado_t;

  estado_t        r_estado;
  logic [1:0]     r_indice;
  logic [3:0]     r_cuenta;
  logic [A-1:0]   r_dir;
  logic [D-1:0]   r_dat;
  logic           r_hab, r_arr, r_ocu, r_err;
  logic [D-1:0]   r_lat_dir, r_lat_lect, r_lat_buf;
`ifdef ESCRITURA_SOLO_CAMBIOS_EN
  logic [D-1:0]   r_sombra [3];
  logic           r_sombra_valida;
`endif

  logic [1:0]     w_desde, w_p;
  logic [2:0]     w_cambia;
  logic [D-1:0]   w_v [3];
  logic [D-1:0]   w_dato;
  logic           w_emitir;

  // First position >= desde that still needs a write; 3 means go straight to DISPARO.
  function automatic logic [1:0] f_siguiente(input logic [1:0] desde, input logic [2:0] cambia);
    if (desde == 2'd0 && cambia[0]) return 2'd0;
    if (desde <= 2'd1 && cambia[1]) return 2'd1;
    if (desde <= 2'd2 && cambia[2]) return 2'd2;
    return 2'd3;
  endfunction

  always_comb begin
    if (r_estado == REPOSO) begin
      w_desde = 2'd0;
      w_v[0]  = direccion_inicio_imagen;
      w_v[1]  = cantidad_lecturas;
      w_v[2]  = D'(cantidad_buffers);
    end else begin
      w_desde = r_indice + 2'd1;
      w_v[0]  = r_lat_dir;
      w_v[1]  = r_lat_lect;
      w_v[2]  = r_lat_buf;
    end
`ifdef ESCRITURA_SOLO_CAMBIOS_EN
    for (int unsigned k = 0; k < 3; k++)
      w_cambia[k] = !r_sombra_valida || (w_v[k] != r_sombra[k]);
`else
    w_cambia = '1;
`endif
    w_p = f_siguiente(w_desde, w_cambia);
    case (w_p)
      2'd0:    w_dato = w_v[0];
      2'd1:    w_dato = w_v[1];
      2'd2:    w_dato = w_v[2];
      default: w_dato = '0;
    endcase
    case (r_estado)
      REPOSO:                                    w_emitir = iniciar && (cantidad_lecturas != '0);
      ESCRIBIR_DIR, ESCRIBIR_LECT, ESCRIBIR_BUF: w_emitir = (N_ESPERA == 4'd0);
      ESPERA:                                    w_emitir = (r_cuenta == 4'd0);
      default:                                   w_emitir = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_estado   <= REPOSO;
      r_indice   <= '0;
      r_cuenta   <= '0;
      r_dir      <= '0;
      r_dat      <= '0;
      r_hab      <= 1'b0;
      r_arr      <= 1'b0;
      r_ocu      <= 1'b0;
      r_err      <= 1'b0;
      r_lat_dir  <= '0;
      r_lat_lect <= '0;
      r_lat_buf  <= '0;
`ifdef ESCRITURA_SOLO_CAMBIOS_EN
      for (int unsigned k = 0; k < 3; k++) r_sombra[k] <= '0;
      r_sombra_valida <= 1'b0;
`endif
    end else begin
      r_hab <= 1'b0;
      r_arr <= 1'b0;
      case (r_estado)
        REPOSO: if (iniciar) begin
          if (cantidad_lecturas == '0) begin
            r_err <= 1'b1;
          end else begin
            r_err      <= 1'b0;
            r_ocu      <= 1'b1;
            r_lat_dir  <= direccion_inicio_imagen;
            r_lat_lect <= cantidad_lecturas;
            r_lat_buf  <= D'(cantidad_buffers);
          end
        end
        ESCRIBIR_DIR, ESCRIBIR_LECT, ESCRIBIR_BUF: if (N_ESPERA != 4'd0) begin
          r_estado <= ESPERA;
          r_cuenta <= N_ESPERA - 4'd1;
        end
        ESPERA: if (r_cuenta != 4'd0) r_cuenta <= r_cuenta - 4'd1;
        DISPARO: begin
          r_estado <= REPOSO;
          r_ocu    <= 1'b0;
        end
        default: r_estado <= REPOSO;
      endcase
      // Next write (or the start pulse) is issued from whichever state just finished.
      if (w_emitir) begin
        r_indice <= w_p;
        case (w_p)
          2'd0:    r_estado <= ESCRIBIR_DIR;
          2'd1:    r_estado <= ESCRIBIR_LECT;
          2'd2:    r_estado <= ESCRIBIR_BUF;
          default: begin
            r_estado <= DISPARO;
            r_arr    <= 1'b1;
          end
        endcase
        if (w_p != 2'd3) begin
          r_hab <= 1'b1;
          r_dir <= BASE + A'(w_p);
          r_dat <= w_dato;
        end
`ifdef ESCRITURA_SOLO_CAMBIOS_EN
        case (w_p)
          2'd0:    r_sombra[0] <= w_dato;
          2'd1:    r_sombra[1] <= w_dato;
          2'd2:    r_sombra[2] <= w_dato;
          default: r_sombra_valida <= 1'b1;
        endcase
`endif
      end
    end
  end

  assign direccion_registros    = r_dir;
  assign datos_registros        = r_dat;
  assign habilitacion_registros = r_hab;
  assign arranque_ventana       = r_arr;
  assign ocupado                = r_ocu;
  assign error_config           = r_err;

endmodule

// File: tb/tb_emisor_configuracion_ventana.sv
// Scoreboard bench: two instances (no wait / base 0, 2-cycle wait / base 2046) share one random request stream.
module tb_emisor_configuracion_ventana;

  localparam int WT [2] = '{0, 2};
  localparam int BS [2] = '{0, 2046};

  typedef struct {
    bit          arr;
    int          cyc;
    logic [10:0] a;
    logic [20:0] d;
  } exp_t;

  logic        clk = 1'b0, reset = 1'b0, iniciar = 1'b0;
  logic [20:0] dir_in = '0, lect_in = '0;
  logic [1:0]  buf_in = '0;
  logic [10:0] dir_o [2];
  logic [20:0] dat_o [2];
  logic        hab_o [2], arr_o [2], ocu_o [2], err_o [2];

  int cyc = 0, n_chk = 0, n_fail = 0;
  exp_t        sb [2][$];
  int          busy_from [2], busy_to [2];
  bit          err_m [2];
  logic [20:0] sh [2][3];
  bit          shv [2];
  logic [10:0] last_a [2];
  logic [20:0] last_d [2];

  emisor_configuracion_ventana #(
    .BITS_BUS_DATOS_INSTR(21), .BITS_BUS_DIRECCION_INSTR(11), .BITS_BUFFERS_IMAGEN(2),
    .DIRECCION_BASE(0), .CICLOS_ESPERA(0)
  ) u0 (
    .clk(clk), .reset(reset), .iniciar(iniciar),
    .direccion_inicio_imagen(dir_in), .cantidad_lecturas(lect_in), .cantidad_buffers(buf_in),
    .direccion_registros(dir_o[0]), .datos_registros(dat_o[0]),
    .habilitacion_registros(hab_o[0]), .arranque_ventana(arr_o[0]),
    .ocupado(ocu_o[0]), .error_config(err_o[0])
  );

  emisor_configuracion_ventana #(
    .BITS_BUS_DATOS_INSTR(21), .BITS_BUS_DIRECCION_INSTR(11), .BITS_BUFFERS_IMAGEN(2),
    .DIRECCION_BASE(2046), .CICLOS_ESPERA(2)
  ) u1 (
    .clk(clk), .reset(reset), .iniciar(iniciar),
    .direccion_inicio_imagen(dir_in), .cantidad_lecturas(lect_in), .cantidad_buffers(buf_in),
    .direccion_registros(dir_o[1]), .datos_registros(dat_o[1]),
    .habilitacion_registros(hab_o[1]), .arranque_ventana(arr_o[1]),
    .ocupado(ocu_o[1]), .error_config(err_o[1])
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, req);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      sb[i].delete();
      busy_from[i] = 0;
      busy_to[i]   = -1;
      err_m[i]     = 1'b0;
      shv[i]       = 1'b0;
      last_a[i]    = '0;
      last_d[i]    = '0;
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Request model: each accepted request yields its list of writes then one start pulse,
  // spaced (wait+1) cycles apart starting the cycle after the sampling edge.
  task automatic pedir(input logic [20:0] a, input logic [20:0] l, input logic [1:0] b);
    int c;
    int n;
    logic [20:0] v [3];
    exp_t e;
    bit need;
    dir_in = a; lect_in = l; buf_in = b; iniciar = 1'b1;
    c = cyc;
    step();
    iniciar = 1'b0;
    v[0] = a; v[1] = l; v[2] = {19'b0, b};
    for (int i = 0; i < 2; i++) begin
      if (c > busy_to[i]) begin
        if (l == 21'd0) begin
          err_m[i] = 1'b1;
        end else begin
          err_m[i] = 1'b0;
          n = 0;
          for (int k = 0; k < 3; k++) begin
`ifdef ESCRITURA_SOLO_CAMBIOS_EN
            need = !shv[i] || (sh[i][k] != v[k]);
`else
            need = 1'b1;
`endif
            if (need) begin
              e.arr = 1'b0; e.cyc = c + 1 + n * (WT[i] + 1);
              e.a = 11'(BS[i] + k); e.d = v[k];
              sb[i].push_back(e);
              sh[i][k] = v[k];
              n++;
            end
          end
          shv[i] = 1'b1;
          e.arr = 1'b1; e.cyc = c + 1 + n * (WT[i] + 1); e.a = '0; e.d = '0;
          sb[i].push_back(e);
          busy_from[i] = c + 1;
          busy_to[i]   = e.cyc;
        end
      end
    end
  endtask

  task automatic do_reset(input int hold);
    reset = 1'b0;
    step();
    model_reset();
    repeat (hold) step();
    reset = 1'b1;
    step();
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 100 && (cyc <= busy_to[0] || cyc <= busy_to[1]); k++) step();
  endtask

  function automatic logic [20:0] pick_addr(input logic [20:0] prev);
    case ($urandom_range(0, 3))
      0:       return 21'h00400;
      1:       return 21'h1FFFFF;
      2:       return prev;
      default: return 21'($urandom);
    endcase
  endfunction

  function automatic logic [20:0] pick_lect(input logic [20:0] prev);
    case ($urandom_range(0, 7))
      0:       return 21'h0;
      1:       return 21'h00001;
      2, 3:    return prev;
      4:       return 21'h00200;
      default: return 21'($urandom);
    endcase
  endfunction

  always @(negedge clk) begin : monitor
    exp_t e;
    for (int i = 0; i < 2; i++) begin
      if (hab_o[i] && arr_o[i]) chk($sformatf("u%0d_hab_and_arr", i), 32'd1, 32'd0);
      chk($sformatf("u%0d_ocupado", i), 32'(ocu_o[i]),
          32'(cyc >= busy_from[i] && cyc <= busy_to[i]));
      chk($sformatf("u%0d_error_config", i), 32'(err_o[i]), 32'(err_m[i]));
      if (hab_o[i] || arr_o[i]) begin
        if (sb[i].size() == 0) begin
          chk($sformatf("u%0d_unexpected_pulse_hab", i), 32'(hab_o[i]), 32'd0);
          chk($sformatf("u%0d_unexpected_pulse_arr", i), 32'(arr_o[i]), 32'd0);
        end else begin
          e = sb[i].pop_front();
          chk($sformatf("u%0d_pulse_is_arranque", i), 32'(arr_o[i]), 32'(e.arr));
          chk($sformatf("u%0d_pulse_cycle", i), 32'(cyc), 32'(e.cyc));
          if (!e.arr) begin
            chk($sformatf("u%0d_write_addr", i), 32'(dir_o[i]), 32'(e.a));
            chk($sformatf("u%0d_write_data", i), 32'(dat_o[i]), 32'(e.d));
            last_a[i] = e.a;
            last_d[i] = e.d;
          end
        end
      end else begin
        while (sb[i].size() > 0 && sb[i][0].cyc < cyc) begin
          e = sb[i].pop_front();
          chk($sformatf("u%0d_missed_event_cycle", i), 32'(cyc), 32'(e.cyc));
        end
        chk($sformatf("u%0d_addr_hold", i), 32'(dir_o[i]), 32'(last_a[i]));
        chk($sformatf("u%0d_data_hold", i), 32'(dat_o[i]), 32'(last_d[i]));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout at cycle %0d: got running, expected finished", cyc);
    $fatal(1, "timeout");
  end

  initial begin : stim
    logic [20:0] pa, pl;
    model_reset();
    repeat (3) step();
    reset = 1'b1;
    step();

    pedir(21'h00400, 21'h00200, 2'd3); wait_idle();
    pedir(21'h00123, 21'h00000, 2'd1); repeat (3) step();
    pedir(21'h00400, 21'h00200, 2'd3); wait_idle();
    pedir(21'h00400, 21'h00200, 2'd3); wait_idle();
    pedir(21'h00400, 21'h00200, 2'd1); wait_idle();

    pedir(21'h00555, 21'h00666, 2'd2); step();
    pedir(21'h00777, 21'h00888, 2'd0); wait_idle();
    pedir(21'h00777, 21'h00000, 2'd0); wait_idle();

    pedir(21'h00abc, 21'h00def, 2'd2); step();
    do_reset(2);
    pedir(21'h00abc, 21'h00def, 2'd2); wait_idle();

    pa = 21'h00400; pl = 21'h00200;
    repeat (80) begin
      repeat ($urandom_range(0, 6)) step();
      if ($urandom_range(0, 15) == 0) do_reset(int'($urandom_range(1, 2)));
      pa = pick_addr(pa);
      pl = pick_lect(pl);
      pedir(pa, pl, 2'($urandom_range(0, 3)));
    end

    wait_idle();
    repeat (2) step();
    chk("u0_events_left", 32'(sb[0].size()), 32'd0);
    chk("u1_events_left", 32'(sb[1].size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
